// File: rtl/pico_core_if.sv
// pico_core_if: program ROM, input handshake, output strobe and status signals of pico_core.
interface pico_core_if #(parameter int N = 8, parameter int P_SIZE = 6, parameter int I_SIZE = N + 16);
    logic [P_SIZE-1:0] imemAddr;
    logic [I_SIZE-1:0] imemData;
    logic [N-1:0] inData;
    logic inValid;
    logic inReady;
    logic [N-1:0] outData;
    logic outValid;
    logic [3:0] flags;
    logic halted;
    modport master (
        output imemAddr, inReady, outData, outValid, flags, halted,
        input imemData, inData, inValid
    );
    modport slave (
        input imemAddr, inReady, outData, outValid, flags, halted,
        output imemData, inData, inValid
    );
endinterface

// File: rtl/pico_core.sv
// pico_core: two-cycle FETCH/EXEC picoMIPS core with flag branches, handshaked IN, strobed OUT and HALT.
module pico_core #(
    parameter int N = 8,
    parameter int P_SIZE = 6,
    parameter int R = 8,
    parameter int I_SIZE = N + 16
) (
    input logic clk,
    input logic rst,
    pico_core_if.master bus
);
    localparam int RW = $clog2(R);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
    state_t state;
    logic [I_SIZE-1:0] ir;
    logic [P_SIZE-1:0] pc;
    logic [N-1:0] rf [R];
    logic [3:0] flg;
    logic [N-1:0] out_data;
    logic out_valid, in_ready, halted;
    logic [5:0] op;
    logic [RW-1:0] rdx, rsx;
    logic [N-1:0] a, b, imm, bo, res;
    logic [N:0] sum, dif;
    logic [2*N-1:0] prod;
    logic c, v, alu, wr, taken, stall;
    assign bus.imemAddr = pc;
    assign bus.inReady = in_ready;
    assign bus.outData = out_data;
    assign bus.outValid = out_valid;
    assign bus.flags = flg;
    assign bus.halted = halted;
    always_comb begin
        op = ir[I_SIZE-1 -: 6];
        rdx = RW'({1'b0, ir[I_SIZE-7 -: 5]} % 6'(R));
        rsx = RW'({1'b0, ir[I_SIZE-12 -: 5]} % 6'(R));
        a = rf[rdx];
        b = rf[rsx];
        imm = ir[N-1:0];
        bo = (op == 6'h08 || op == 6'h09) ? imm : b;
        sum = {1'b0, a} + {1'b0, bo};
        dif = {1'b0, a} - {1'b0, bo};
        prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        res = '0;
        c = 1'b0;
        v = 1'b0;
        wr = 1'b1;
        alu = 1'b1;
        case (op)
            6'h01, 6'h08: begin
                res = sum[N-1:0];
                c = sum[N];
                v = (a[N-1] == bo[N-1]) && (res[N-1] != a[N-1]);
            end
            6'h02, 6'h09: begin
                res = dif[N-1:0];
                c = dif[N];
                v = (a[N-1] != bo[N-1]) && (res[N-1] != a[N-1]);
            end
            6'h03: res = a & b;
            6'h04: res = a | b;
            6'h05: res = a ^ b;
            6'h06: res = prod[N-1:0];
            6'h07: res = prod[2*N-1:N];
            6'h0A: begin res = imm; alu = 1'b0; end
            6'h0B: begin res = b; alu = 1'b0; end
            6'h10: begin res = bus.inData; alu = 1'b0; end
            default: begin wr = 1'b0; alu = 1'b0; end
        endcase
        taken = (op == 6'h18 && flg[3]) || (op == 6'h19 && !flg[3]) || op == 6'h1A;
        stall = op == 6'h10 && !bus.inValid;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc <= '0;
            ir <= '0;
            flg <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
            in_ready <= 1'b0;
            halted <= 1'b0;
            for (int i = 0; i < R; i++) rf[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                FETCH: begin
                    ir <= bus.imemData;
                    in_ready <= bus.imemData[I_SIZE-1 -: 6] == 6'h10;
                    state <= EXEC;
                end
                EXEC: if (!stall) begin
                    state <= op == 6'h3F ? HALT : FETCH;
                    halted <= op == 6'h3F;
                    in_ready <= 1'b0;
                    pc <= taken ? imm[P_SIZE-1:0] : pc + P_SIZE'(1);
                    if (wr && rdx != '0) rf[rdx] <= res;
                    if (alu) flg <= {res == '0, res[N-1], c, v};
                    if (op == 6'h11) begin
                        out_data <= b;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pico_core.sv
// tb_pico_core: directed programs plus random programs, checked every cycle against an instruction-level model.
module tb_pico_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic in_valid = 1'b0;
    logic [23:0] rom [64];
    int checks = 0, errors = 0, rdy_cnt = 0;
    bit rnd_in = 0;
    logic [5:0] m_pc;
    logic [23:0] m_ir;
    logic [7:0] m_r [8];
    logic [3:0] m_f;
    logic [7:0] m_out;
    logic m_ov, m_halt, m_exec;
    int ops [20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 16, 17, 24, 25, 26, 63, 12, 47};

    always #5 clk = ~clk;

    pico_core_if #(.N(8), .P_SIZE(6), .I_SIZE(24)) bus ();
    pico_core #(.N(8), .P_SIZE(6), .R(8), .I_SIZE(24)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.imemData = rom[bus.imemAddr];
    assign bus.inData = in_data;
    assign bus.inValid = in_valid;

    function automatic logic [23:0] ins(input int op, input int rd, input int rs, input int imm);
        return {op[5:0], rd[4:0], rs[4:0], imm[7:0]};
    endfunction

    function automatic int sgn(input int x);
        return x >= 128 ? x - 256 : x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge of the architectural model: a whole instruction retires at its EXEC edge.
    task automatic model_edge();
        int op, d, s, imm, a, b, x, t, sv, res, nxt;
        bit c, v, setf;
        if (rst) begin
            m_pc = 0; m_ir = 0; m_f = 0; m_out = 0; m_ov = 0; m_halt = 0; m_exec = 0;
            for (int i = 0; i < 8; i++) m_r[i] = 0;
            return;
        end
        m_ov = 0;
        if (m_halt) return;
        if (!m_exec) begin
            m_ir = rom[m_pc];
            m_exec = 1;
            return;
        end
        op = int'(m_ir[23:18]);
        d = int'(m_ir[17:13]) % 8;
        s = int'(m_ir[12:8]) % 8;
        imm = int'(m_ir[7:0]);
        a = int'(m_r[d]);
        b = int'(m_r[s]);
        if (op == 16 && !in_valid) return;
        m_exec = 0;
        nxt = (int'(m_pc) + 1) % 64;
        res = -1; c = 0; v = 0; setf = 0;
        x = (op == 8 || op == 9) ? imm : b;
        case (op)
            1, 8: begin t = a + x; res = t % 256; c = t > 255; sv = sgn(a) + sgn(x); v = sv > 127 || sv < -128; setf = 1; end
            2, 9: begin t = a - x; res = (t + 256) % 256; c = a < x; sv = sgn(a) - sgn(x); v = sv > 127 || sv < -128; setf = 1; end
            3: begin res = a & b; setf = 1; end
            4: begin res = a | b; setf = 1; end
            5: begin res = a ^ b; setf = 1; end
            6: begin res = (a * b) % 256; setf = 1; end
            7: begin res = (a * b) / 256; setf = 1; end
            10: res = imm;
            11: res = b;
            16: res = int'(in_data);
            17: begin m_out = 8'(b); m_ov = 1; end
            24: if (m_f[3]) nxt = imm % 64;
            25: if (!m_f[3]) nxt = imm % 64;
            26: nxt = imm % 64;
            63: m_halt = 1;
            default: ;
        endcase
        if (res >= 0 && d != 0) m_r[d] = 8'(res);
        if (setf) m_f = {res == 0, res >= 128, c, v};
        m_pc = 6'(nxt);
    endtask

    task automatic compare();
        check("imemAddr", 32'(bus.imemAddr), 32'(m_pc));
        check("outData", 32'(bus.outData), 32'(m_out));
        check("outValid", 32'(bus.outValid), 32'(m_ov));
        check("flags", 32'(bus.flags), 32'(m_f));
        check("inReady", 32'(bus.inReady), 32'(m_exec && !m_halt && m_ir[23:18] == 6'h10));
        check("halted", 32'(bus.halted), 32'(m_halt));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare();
            if (bus.inReady) rdy_cnt++;
            if (rnd_in) begin
                in_valid = 1'($urandom % 2);
                in_data = 8'($urandom);
            end
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 24'h0;
    endtask

    task automatic restart();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        clear_rom();
        rom[0] = ins(10, 1, 0, 5);
        rom[1] = ins(10, 2, 0, 3);
        rom[2] = ins(1, 1, 2, 0);
        rom[3] = ins(17, 0, 1, 0);
        restart();
        check("rst_addr", 32'(bus.imemAddr), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_outValid", 32'(bus.outValid), 32'd0);
        check("rst_inReady", 32'(bus.inReady), 32'd0);
        run(8);
        check("add_out", 32'(bus.outData), 32'd8);
        check("add_strobe", 32'(bus.outValid), 32'd1);
        check("add_flags", 32'(bus.flags), 32'b0000);
        run(1);
        check("add_strobe_end", 32'(bus.outValid), 32'd0);

        clear_rom();
        rom[0] = ins(10, 1, 0, 8'h80);
        rom[1] = ins(8, 1, 0, 8'h80);
        rom[2] = ins(24, 0, 0, 8'h20);
        restart();
        run(4);
        check("addi_flags", 32'(bus.flags), 32'b1011);
        run(2);
        check("beq_target", 32'(bus.imemAddr), 32'h20);

        clear_rom();
        rom[0] = ins(10, 1, 0, 8'h10);
        rom[1] = ins(10, 2, 0, 8'h20);
        rom[2] = ins(7, 1, 2, 0);
        rom[3] = ins(17, 0, 1, 0);
        rom[4] = ins(10, 1, 0, 8'h10);
        rom[5] = ins(6, 1, 2, 0);
        rom[6] = ins(17, 0, 1, 0);
        restart();
        run(8);
        check("mulh_out", 32'(bus.outData), 32'h02);
        run(4);
        check("mul_flags", 32'(bus.flags), 32'b1000);
        run(2);
        check("mul_out", 32'(bus.outData), 32'h00);

        clear_rom();
        rom[0] = ins(16, 3, 0, 0);
        rom[1] = ins(17, 0, 3, 0);
        rom[2] = ins(63, 0, 0, 0);
        in_valid = 1'b0;
        restart();
        rdy_cnt = 0;
        run(5);
        in_data = 8'hA5;
        in_valid = 1'b1;
        run(1);
        in_valid = 1'b0;
        check("in_ready_cycles", 32'(rdy_cnt), 32'd5);
        run(2);
        check("in_out", 32'(bus.outData), 32'hA5);
        check("in_out_strobe", 32'(bus.outValid), 32'd1);

        clear_rom();
        rom[0] = ins(10, 1, 0, 3);
        rom[1] = ins(9, 1, 0, 1);
        rom[2] = ins(25, 0, 0, 1);
        rom[3] = ins(63, 0, 0, 0);
        restart();
        run(15);
        check("loop_not_halted", 32'(bus.halted), 32'd0);
        run(5);
        check("loop_halted", 32'(bus.halted), 32'd1);
        run(3);
        check("halt_addr_frozen", 32'(bus.imemAddr), 32'd4);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        check("halt_rst_addr", 32'(bus.imemAddr), 32'd0);
        check("halt_rst_halted", 32'(bus.halted), 32'd0);

        clear_rom();
        rom[0] = ins(10, 3, 0, 7);
        rom[1] = ins(16, 2, 0, 0);
        restart();
        run(3);
        check("in_wait_ready", 32'(bus.inReady), 32'd1);
        rst = 1'b1;
        run(1);
        check("in_wait_rst_ready", 32'(bus.inReady), 32'd0);
        rom[0] = ins(17, 0, 3, 0);
        rom[1] = 24'h0;
        rst = 1'b0;
        run(2);
        check("rst_reg_cleared", 32'(bus.outData), 32'd0);
        check("rst_reg_strobe", 32'(bus.outValid), 32'd1);

        clear_rom();
        rom[0] = ins(26, 0, 0, 63);
        restart();
        run(2);
        check("jmp_63", 32'(bus.imemAddr), 32'd63);
        run(2);
        check("pc_wrap", 32'(bus.imemAddr), 32'd0);

        for (int p = 0; p < 5; p++) begin
            clear_rom();
            for (int i = 0; i < 48; i++)
                rom[i] = ins(ops[$urandom % 20], int'($urandom % 32), int'($urandom % 32), int'($urandom % 256));
            rnd_in = 1;
            restart();
            run(300);
            rnd_in = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
